// File: rtl/mdiv_seq_if.sv
// Operand/result handshake bundle for the sequential mantissa divider.
// The producer/consumer side uses master; the divider uses slave.
interface mdiv_seq_if #(
  parameter int WIDTH = 23,
  parameter int GUARD = 3
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] m1;
  logic [WIDTH-1:0] m2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] m3;
  logic [GUARD-1:0] guard;
  logic             sticky;
  logic             decrement_exponent;
  logic             busy;

  modport master (
    output flush, in_valid, m1, m2, out_ready,
    input  in_ready, out_valid, m3, guard, sticky, decrement_exponent, busy
  );

  modport slave (
    input  flush, in_valid, m1, m2, out_ready,
    output in_ready, out_valid, m3, guard, sticky, decrement_exponent, busy
  );
endinterface

// File: rtl/mdiv_seq.sv
// Radix-2 restoring divider for {1,m1}/{1,m2}, one quotient bit per clock,
// producing a normalised fraction with guard/sticky for the rounder.
module mdiv_seq #(
  parameter int WIDTH = 23,
  parameter int GUARD = 3
) (
  input logic        clk,
  input logic        rst_n,
  mdiv_seq_if.slave  bus
);
  localparam int N  = WIDTH + GUARD + 2;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH+1:0] rem_q, rem_d;
  logic [WIDTH:0]   div_q, div_d;
  // Holds N-1 bits; the last quotient bit is only needed combinationally on the final edge.
  logic [N-2:0]     quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] m3_q, m3_d;
  logic [GUARD-1:0] guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic             dec_q, dec_d;

  logic [WIDTH+1:0] div_ext;
  logic [WIDTH+1:0] rem_sub;
  logic             qbit;
  logic [N-1:0]     quo_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      m3_q     <= '0;
      guard_q  <= '0;
      sticky_q <= 1'b0;
      dec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      m3_q     <= m3_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      dec_q    <= dec_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    m3_d     = m3_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    dec_d    = dec_q;

    div_ext = {1'b0, div_q};
    qbit    = (rem_q >= div_ext);
    rem_sub = qbit ? (rem_q - div_ext) : rem_q;
    quo_nxt = {quo_q, qbit};

    case (state_q)
      IDLE: begin
        if (!bus.flush && bus.in_valid) begin
          rem_d   = {1'b0, 1'b1, bus.m1};
          div_d   = {1'b1, bus.m2};
          quo_d   = '0;
          cnt_d   = CW'(N - 1);
          state_d = ITER;
        end
      end
      ITER: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          quo_d = quo_nxt[N-2:0];
          rem_d = {rem_sub[WIDTH:0], 1'b0};
          if (cnt_q == '0) begin
            state_d = DONE;
            // Quotient lies in (0.5, 2): either bit N-1 or bit N-2 leads.
            if (quo_nxt[N-1]) begin
              m3_d     = quo_nxt[N-2 -: WIDTH];
              guard_d  = quo_nxt[GUARD -: GUARD];
              sticky_d = quo_nxt[0] | (rem_sub != '0);
              dec_d    = 1'b0;
            end else begin
              m3_d     = quo_nxt[N-3 -: WIDTH];
              guard_d  = quo_nxt[GUARD-1:0];
              sticky_d = (rem_sub != '0);
              dec_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.flush || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready           = (state_q == IDLE);
  assign bus.busy               = (state_q == ITER);
  assign bus.out_valid          = (state_q == DONE);
  assign bus.m3                 = m3_q;
  assign bus.guard              = guard_q;
  assign bus.sticky             = sticky_q;
  assign bus.decrement_exponent = dec_q;
endmodule

// File: tb/tb_mdiv_seq.sv
// Bench for mdiv_seq at WIDTH=23 (slot 0) and WIDTH=52 (slot 1), checked
// against the exact rational quotient of the two significands.
module tb_mdiv_seq;
  localparam int G = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        iv [2];
  logic        ordy [2];
  logic        fl [2];
  logic [51:0] a_v [2];
  logic [51:0] b_v [2];
  logic        ov [2];
  logic        ir [2];
  logic        bz [2];
  logic        st [2];
  logic        de [2];
  logic [51:0] m3w [2];
  logic [2:0]  gw [2];

  logic [51:0] last_m3;
  logic [2:0]  last_g;
  bit          watch = 1'b0;
  bit          seen_ov = 1'b0;

  mdiv_seq_if #(.WIDTH(23), .GUARD(3)) if23 ();
  mdiv_seq_if #(.WIDTH(52), .GUARD(3)) if52 ();

  mdiv_seq #(.WIDTH(23), .GUARD(3)) dut23 (.clk(clk), .rst_n(rst_n), .bus(if23));
  mdiv_seq #(.WIDTH(52), .GUARD(3)) dut52 (.clk(clk), .rst_n(rst_n), .bus(if52));

  assign if23.in_valid  = iv[0];
  assign if23.out_ready = ordy[0];
  assign if23.flush     = fl[0];
  assign if23.m1        = a_v[0][22:0];
  assign if23.m2        = b_v[0][22:0];
  assign if52.in_valid  = iv[1];
  assign if52.out_ready = ordy[1];
  assign if52.flush     = fl[1];
  assign if52.m1        = a_v[1];
  assign if52.m2        = b_v[1];

  assign ov[0]  = if23.out_valid;
  assign ir[0]  = if23.in_ready;
  assign bz[0]  = if23.busy;
  assign st[0]  = if23.sticky;
  assign de[0]  = if23.decrement_exponent;
  assign m3w[0] = {29'd0, if23.m3};
  assign gw[0]  = if23.guard;
  assign ov[1]  = if52.out_valid;
  assign ir[1]  = if52.in_ready;
  assign bz[1]  = if52.busy;
  assign st[1]  = if52.sticky;
  assign de[1]  = if52.decrement_exponent;
  assign m3w[1] = if52.m3;
  assign gw[1]  = if52.guard;

  always @(negedge clk) if (watch && ov[0] === 1'b1) seen_ov = 1'b1;

  function automatic int wid(input int s);
    return (s == 1) ? 52 : 23;
  endfunction

  // Exact quotient (1.a)/(1.b) scaled so the leading one sits just above WIDTH+GUARD bits.
  function automatic void ref_div(input int w, input logic [51:0] af, input logic [51:0] bf,
                                  output logic [51:0] m3, output logic [2:0] g,
                                  output logic s, output logic d);
    logic [127:0] a, b, num, q, r, fmask;
    fmask = (128'd1 << w) - 128'd1;
    a = (128'd1 << w) | ({76'd0, af} & fmask);
    b = (128'd1 << w) | ({76'd0, bf} & fmask);
    if (a >= b) begin
      d = 1'b0;
      num = a << (w + G);
    end else begin
      d = 1'b1;
      num = a << (w + G + 1);
    end
    q = num / b;
    r = num % b;
    g = q[2:0];
    m3 = 52'((q >> 3) & fmask);
    s = (r != 128'd0);
  endfunction

  task automatic do_op(input int s, input logic [51:0] a, input logic [51:0] b,
                       input bit rnd, input int stall, input bit have_exp,
                       input logic [51:0] xm3, input logic [2:0] xg, input logic xs,
                       input logic xd, input string tag);
    int w, lat, k;
    logic [51:0] em3;
    logic [2:0] eg;
    logic es, ed;
    bit bad, done;
    w = wid(s);
    if (have_exp) begin
      em3 = xm3; eg = xg; es = xs; ed = xd;
    end else begin
      ref_div(w, a, b, em3, eg, es, ed);
    end
    k = 0;
    while (ir[s] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    iv[s] = 1'b1;
    a_v[s] = a;
    b_v[s] = b;
    @(negedge clk);
    iv[s] = 1'b0;
    a_v[s] = 52'({$urandom, $urandom});
    b_v[s] = 52'({$urandom, $urandom});
    lat = 0;
    while (ov[s] !== 1'b1 && lat < w + G + 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != w + G + 2) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, w + G + 2);
    end
    checks++;
    if (m3w[s] !== em3) begin
      errors++;
      $display("FAIL %s m3: got %h want %h", tag, m3w[s], em3);
    end
    checks++;
    if (gw[s] !== eg) begin
      errors++;
      $display("FAIL %s guard: got %b want %b", tag, gw[s], eg);
    end
    checks++;
    if (st[s] !== es) begin
      errors++;
      $display("FAIL %s sticky: got %b want %b", tag, st[s], es);
    end
    checks++;
    if (de[s] !== ed) begin
      errors++;
      $display("FAIL %s decrement_exponent: got %b want %b", tag, de[s], ed);
    end
    k = 0;
    done = 1'b0;
    bad = 1'b0;
    while (!done && k < 1000) begin
      if (k < stall) begin
        ordy[s] = 1'b0;
        iv[s] = 1'b1;
      end else begin
        ordy[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        iv[s] = 1'b0;
      end
      if (ov[s] !== 1'b1 || ir[s] !== 1'b0 || m3w[s] !== em3 || gw[s] !== eg ||
          st[s] !== es || de[s] !== ed) bad = 1'b1;
      if (ordy[s] === 1'b1) done = 1'b1;
      @(negedge clk);
      k++;
    end
    ordy[s] = 1'b0;
    iv[s] = 1'b0;
    checks++;
    if (bad || !done) begin
      errors++;
      $display("FAIL %s hold_in_done: got bad=%0b done=%0b want bad=0 done=1", tag, bad, done);
    end
    checks++;
    if (ir[s] !== 1'b1 || ov[s] !== 1'b0) begin
      errors++;
      $display("FAIL %s after_transfer: got in_ready=%b out_valid=%b want 1 0", tag, ir[s], ov[s]);
    end
    last_m3 = em3;
    last_g = eg;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (ir[s] !== 1'b1 || ov[s] !== 1'b0 || bz[s] !== 1'b0 || m3w[s] !== 52'd0 ||
          gw[s] !== 3'd0 || st[s] !== 1'b0 || de[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_w%0d: got ir=%b ov=%b busy=%b m3=%h g=%b st=%b de=%b want 1 0 0 0 0 0 0",
                 wid(s), ir[s], ov[s], bz[s], m3w[s], gw[s], st[s], de[s]);
      end
    end
  endtask

  task automatic test_directed();
    do_op(0, 52'd0, 52'd0, 1'b0, 0, 1'b1, 52'd0, 3'b000, 1'b0, 1'b0, "one_by_one");
    do_op(0, 52'd0, 52'h400000, 1'b0, 0, 1'b1, 52'h2AAAAA, 3'b101, 1'b1, 1'b1, "one_by_1p5");
    do_op(0, 52'h7FFFFF, 52'd0, 1'b0, 0, 1'b1, 52'h7FFFFF, 3'b000, 1'b0, 1'b0, "max_by_one");
    do_op(1, 52'd0, 52'd0, 1'b0, 0, 1'b1, 52'd0, 3'b000, 1'b0, 1'b0, "one_by_one_w52");
    do_op(1, 52'd0, 52'h8_0000_0000_0000, 1'b0, 0, 1'b0, 52'd0, 3'd0, 1'b0, 1'b0, "one_by_1p5_w52");
  endtask

  task automatic test_stall();
    do_op(0, 52'h123456, 52'h654321, 1'b0, 10, 1'b0, 52'd0, 3'd0, 1'b0, 1'b0, "stall_first");
    do_op(0, 52'h3C0FFE, 52'h0BEEF1, 1'b0, 0, 1'b0, 52'd0, 3'd0, 1'b0, 1'b0, "stall_second");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_op(0, 52'($urandom), 52'($urandom), 1'b0, 0, 1'b0, 52'd0, 3'd0, 1'b0, 1'b0, "b2b");
  endtask

  task automatic test_flush_reset();
    int k;
    watch = 1'b1;
    seen_ov = 1'b0;
    k = 0;
    while (ir[0] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    iv[0] = 1'b1;
    a_v[0] = 52'h1111;
    b_v[0] = 52'h2222;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bz[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_busy: got %b want 1", bz[0]);
    end
    fl[0] = 1'b1;
    @(negedge clk);
    fl[0] = 1'b0;
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got ir=%b ov=%b busy=%b want 1 0 0", ir[0], ov[0], bz[0]);
    end
    checks++;
    if (m3w[0] !== last_m3 || gw[0] !== last_g) begin
      errors++;
      $display("FAIL flush_hold: got m3=%h g=%b want m3=%h g=%b", m3w[0], gw[0], last_m3, last_g);
    end
    iv[0] = 1'b1;
    a_v[0] = 52'h7ABCDE;
    b_v[0] = 52'h012345;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0 || m3w[0] !== 52'd0 ||
        gw[0] !== 3'd0 || st[0] !== 1'b0 || de[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got ir=%b ov=%b busy=%b m3=%h g=%b st=%b de=%b want 1 0 0 0 0 0 0",
               ir[0], ov[0], bz[0], m3w[0], gw[0], st[0], de[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    watch = 1'b0;
    checks++;
    if (seen_ov !== 1'b0) begin
      errors++;
      $display("FAIL aborted_out_valid: got %b want 0", seen_ov);
    end
    do_op(0, 52'h400000, 52'h400000, 1'b0, 0, 1'b1, 52'd0, 3'b000, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_random(input int s, input int n);
    logic [51:0] mask, a, b;
    mask = (52'd1 << wid(s)) - 52'd1;
    if (s == 1) mask = {52{1'b1}};
    for (int i = 0; i < n; i++) begin
      a = 52'({$urandom, $urandom}) & mask;
      b = 52'({$urandom, $urandom}) & mask;
      if (i == 0) begin a = mask; b = mask; end
      if (i == 1) begin a = 52'd0; b = mask; end
      if (i == 2) begin a = mask; b = 52'd0; end
      do_op(s, a, b, 1'b1, 0, 1'b0, 52'd0, 3'd0, 1'b0, 1'b0, (s == 1) ? "rand_w52" : "rand_w23");
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0;
      ordy[s] = 1'b0;
      fl[s] = 1'b0;
      a_v[s] = 52'd0;
      b_v[s] = 52'd0;
    end
    last_m3 = 52'd0;
    last_g = 3'd0;
    #23;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_directed();
    test_stall();
    test_back_to_back();
    test_flush_reset();
    test_random(0, 1000);
    test_random(1, 250);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
